// File: rtl/full_adder_module.sv
// full_adder_module: registered ripple-carry adder built from 1-bit full-adder cells.
// Define FULL_ADDER_MODULE_OVF_EN to add a registered two's-complement overflow output ovf.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module full_adder_module #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_MODULE_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;
  assign carry[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .x (a[i]),
      .y (b[i]),
      .ci(carry[i]),
      .s (s[i]),
      .co(carry[i+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= carry[WIDTH];
      end
    end
  end
`ifdef FULL_ADDER_MODULE_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (in_valid) ovf <= carry[WIDTH] ^ carry[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_full_adder_module.sv
// tb_full_adder_module: drives WIDTH=1/4/8 adders together against a queued reference model.
module tb_full_adder_module;
  typedef struct {
    string       tag;
    int          id;
    logic [10:0] exp;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v[3];
  logic [7:0] ia[3];
  logic [7:0] ib[3];
  logic       ic[3];
  logic [0:0] sum1;
  logic [3:0] sum4;
  logic [7:0] sum8;
  logic       co[3];
  logic       ov[3];
  logic       of[3];
  logic [7:0] ms[3];
  logic       mc[3];
  logic       mv[3];
  logic       mo[3];
  int         w[3] = '{1, 4, 8};
  item_t      sb[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  full_adder_module #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .a(ia[0][0:0]), .b(ib[0][0:0]), .cin(ic[0]),
    .sum(sum1), .cout(co[0]), .out_valid(ov[0])
`ifdef FULL_ADDER_MODULE_OVF_EN
    , .ovf(of[0])
`endif
  );
  full_adder_module #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .a(ia[1][3:0]), .b(ib[1][3:0]), .cin(ic[1]),
    .sum(sum4), .cout(co[1]), .out_valid(ov[1])
`ifdef FULL_ADDER_MODULE_OVF_EN
    , .ovf(of[1])
`endif
  );
  full_adder_module #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .a(ia[2]), .b(ib[2]), .cin(ic[2]),
    .sum(sum8), .cout(co[2]), .out_valid(ov[2])
`ifdef FULL_ADDER_MODULE_OVF_EN
    , .ovf(of[2])
`endif
  );

  function automatic logic [10:0] observed(int id);
    logic [7:0] s;
    logic       o;
    s = id == 0 ? {7'd0, sum1} : id == 1 ? {4'd0, sum4} : sum8;
`ifdef FULL_ADDER_MODULE_OVF_EN
    o = of[id];
`else
    o = 1'b0;
`endif
    return {o, ov[id], co[id], s};
  endfunction

  // Predict each instance's next registered state, then check it one edge later.
  task automatic tick(input string tag);
    for (int id = 0; id < 3; id++) begin
      int m, fa, fb, full, sa, sb_, ss;
      item_t it;
      m  = (1 << w[id]) - 1;
      fa = int'(ia[id]) & m;
      fb = int'(ib[id]) & m;
      if (rst) begin
        ms[id] = '0; mc[id] = 1'b0; mv[id] = 1'b0; mo[id] = 1'b0;
      end else if (v[id]) begin
        full   = fa + fb + int'(ic[id]);
        ms[id] = 8'(full & m);
        mc[id] = ((full >> w[id]) & 1) != 0;
        mv[id] = 1'b1;
        sa  = (fa >> (w[id] - 1)) & 1;
        sb_ = (fb >> (w[id] - 1)) & 1;
        ss  = (int'(ms[id]) >> (w[id] - 1)) & 1;
        mo[id] = (sa == sb_) && (ss != sa);
      end else begin
        mv[id] = 1'b0;
      end
      it.tag = tag;
      it.id  = id;
`ifdef FULL_ADDER_MODULE_OVF_EN
      it.exp = {mo[id], mv[id], mc[id], ms[id]};
`else
      it.exp = {1'b0, mv[id], mc[id], ms[id]};
`endif
      sb.push_back(it);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      item_t it;
      logic [10:0] got;
      it  = sb.pop_front();
      got = observed(it.id);
      checks++;
      assert (got === it.exp)
      else begin
        errors++;
        $error("FAIL %s id=%0d observed %h expected %h", it.tag, it.id, got, it.exp);
      end
    end
  endtask

  task automatic drive(input int id, input logic vv, input int a, input int b, input logic c);
    v[id]  = vv;
    ia[id] = 8'(a);
    ib[id] = 8'(b);
    ic[id] = c;
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      drive(id, 1'b0, 0, 0, 1'b0);
      ms[id] = '0; mc[id] = 1'b0; mv[id] = 1'b0; mo[id] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick("reset");
    tick("reset");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, (i >> 2) & 1, (i >> 1) & 1, i[0]);
      tick("w1_exhaustive");
      tick("w1_exhaustive");
    end
    drive(0, 1'b1, 1, 1, 1'b1);
    tick("w1_load111");
    rst = 1'b1;
    tick("reset_priority");
    rst = 1'b0;
    drive(0, 1'b1, 1, 0, 1'b0);
    tick("hold_capture");
    drive(0, 1'b0, 1, 1, 1'b1);
    repeat (3) tick("hold");
    drive(1, 1'b1, 15, 1, 1'b0);
    tick("w4_wrap_f_1");
    drive(1, 1'b1, 15, 15, 1'b1);
    tick("w4_wrap_f_f_1");
    drive(1, 1'b1, 7, 1, 1'b0);
    tick("w4_ovf_7_1");
    drive(1, 1'b1, 15, 1, 1'b0);
    tick("w4_ovf_f_1");
    drive(1, 1'b1, 8, 8, 1'b0);
    tick("w4_ovf_8_8");
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b1, 255, 255, 1'b1);
    tick("w8_all_ones");
    for (int n = 0; n < 1000; n++) begin
      for (int id = 0; id < 3; id++)
        drive(id, n < 200 ? 1'b1 : 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
      rst = ($urandom_range(0, 49) == 0);
      tick("random");
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_adder_module.md
Name: full_adder_module

Overview:
- Registered ripple-carry adder assembled from instances of a 1-bit full-adder cell (structural module-instance style).
- Adds operands a and b and carry-in cin, producing a registered sum and carry-out.
- Default WIDTH=1 gives a classic single-bit full adder with a register stage.
- Used as an arithmetic leaf in datapaths and as the reference structural adder for the basic-logic library.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle; capture enable.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.
- out_valid  output  1  sum/cout updated from an accepted input.

Behaviour:
- Cell: a 1-bit full-adder submodule, instantiated WIDTH times.
  - s = x ^ y ^ ci
  - co = (x & y) | (ci & (x ^ y))
- Chain: carry[0]=cin; carry[i+1]=co of cell i; cout source = carry[WIDTH].
- Combinational result {carry[WIDTH], s[WIDTH-1:0]} must equal a + b + cin in WIDTH+1 bits.
- Register stage: all outputs are flops updated on the rising edge of clk only.
- Reset (rst=1 at an edge): sum=0, cout=0, out_valid=0. Reset takes priority over in_valid in the same cycle.
  - Reset asserted mid-stream discards any result not yet registered.
  - The first capture after reset is the first edge with rst=0 and in_valid=1.
- in_valid=1 at an edge (rst=0): sum/cout load the combinational result; out_valid<=1.
- in_valid=0 at an edge (rst=0): sum/cout hold their previous values; out_valid<=0.
- Latency is exactly 1 clock from operand capture to output.
- Throughput is 1 result per cycle; no backpressure. Back-to-back in_valid is fully supported.
- Wrap-around: all-ones + all-ones + 1 gives sum=all-ones, cout=1. There is no saturation.
- X/undefined handling is not required; inputs are assumed driven whenever in_valid=1.
- No latches. No combinational path from any input to any output.

Optional Feature:
- Macro: FULL_ADDER_MODULE_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum with identical reset (0) and hold rules.
  - ovf = carry[WIDTH] ^ carry[WIDTH-1], i.e. two's-complement signed overflow.
  - For WIDTH=1, ovf = cout ^ cin.
- Not defined: port ovf is absent and no overflow logic is synthesized.
- sum/cout/out_valid behaviour is identical in both builds.

Test Plan:
- WIDTH=1 exhaustive: apply a,b,cin = 000,001,010,011,100,101,110,111 with in_valid=1, each held 2 cycles. One cycle later sum/cout must be 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1, and out_valid=1.
- Reset: load a=1,b=1,cin=1 (sum=1,cout=1), then assert rst for 1 cycle with in_valid=1 → sum=0, cout=0, out_valid=0 after that edge.
- Hold: capture a=1,b=0,cin=0 (sum=1), then drive a=1,b=1,cin=1 with in_valid=0 for 3 cycles → sum=1, cout=0, out_valid=0 throughout.
- WIDTH=4 wrap: a=4'hF, b=4'h1, cin=0 → sum=4'h0, cout=1; then a=4'hF, b=4'hF, cin=1 → sum=4'hF, cout=1.
- WIDTH=8 random: 1000 back-to-back vectors → each {cout,sum} equals a+b+cin of the previous cycle, and out_valid tracks in_valid delayed by 1.
- OVF build, WIDTH=4: a=4'h7, b=4'h1, cin=0 → sum=4'h8, ovf=1; a=4'hF, b=4'h1 → ovf=0.
